// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared board constants and button FSM state encoding
package lab_pkg;

  localparam int CLK_HZ = 100_000_000;

  localparam logic [1:0] ST_REL      = 2'd0;
  localparam logic [1:0] ST_DB_PRESS = 2'd1;
  localparam logic [1:0] ST_PRS      = 2'd2;
  localparam logic [1:0] ST_DB_REL   = 2'd3;

  typedef enum logic [1:0] {
    REL      = ST_REL,
    DB_PRESS = ST_DB_PRESS,
    PRS      = ST_PRS,
    DB_REL   = ST_DB_REL
  } btn_state_e;

endpackage

// File: rtl/pause_button_ctrl_if.sv
// rtl/pause_button_ctrl_if.sv - button pin in, conditioned pause controls out
interface pause_button_ctrl_if;

  logic btn_n;
  logic btn_db_n;
  logic press_pulse;
  logic pause_n;

  modport master (
    output btn_n,
    input  btn_db_n,
    input  press_pulse,
    input  pause_n
  );

  modport slave (
    input  btn_n,
    output btn_db_n,
    output press_pulse,
    output pause_n
  );

endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage synchroniser, resets to 1 (idle level of active-low pins)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '1;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pause_button_ctrl.sv
// rtl/pause_button_ctrl.sv - debounces the PAUSE button and toggles the run/pause level
module pause_button_ctrl
  import lab_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = CLK_HZ / 50
) (
  input  logic                clk,
  input  logic                rst_n,
  pause_button_ctrl_if.slave  btn_if
);

  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s_n;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             db_n_q;
  logic             pulse_q;
  logic             pause_n_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_if.btn_n),
    .q     (s_n)
  );

  // Counter holds the number of consecutive samples that disagree with the
  // accepted level; any agreeing sample restarts it, so it stops at CNT_LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= REL;
      cnt       <= '0;
      db_n_q    <= 1'b1;
      pulse_q   <= 1'b0;
      pause_n_q <= 1'b1;
    end else begin
      pulse_q <= 1'b0;
      case (state)
        REL: begin
          if (!s_n) begin
            state <= DB_PRESS;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        DB_PRESS: begin
          if (s_n) begin
            state <= REL;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= PRS;
            cnt       <= '0;
            db_n_q    <= 1'b0;
            pulse_q   <= 1'b1;
            pause_n_q <= ~pause_n_q;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRS: begin
          if (s_n) begin
            state <= DB_REL;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        DB_REL: begin
          if (!s_n) begin
            state <= PRS;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= REL;
            cnt    <= '0;
            db_n_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= REL;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign btn_if.btn_db_n    = db_n_q;
  assign btn_if.press_pulse = pulse_q;
  assign btn_if.pause_n     = pause_n_q;

endmodule

// File: doc/pause_button_ctrl.md
Name: pause_button_ctrl

Overview:
- Front-end conditioning for the raw, bouncy, active-low PAUSE push-button.
- Synchronises the button to clk, debounces it with a stable-time counter and FSM, and emits one press pulse per physical press.
- Maintains a toggled run/pause level, pause_n, that drives the pause input of the counting adder stage directly.
- Sits between the board button pin and the counter/display datapath.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchroniser (legal range 2..4).
- CNT_MAX, 2_000_000: consecutive stable cycles needed to accept a level change (20 ms at 100 MHz); legal range 2..2^24.
- CNT_W, $clog2(CNT_MAX): stable-counter width; derived, never overridden.

Ports:
- clk, input, 1: system clock; sole clock domain.
- rst_n, input, 1: asynchronous active-low reset, de-asserted synchronously externally.
- btn_n, input, 1: raw button pin, 0 = pressed; asynchronous to clk, may bounce.
- btn_db_n, output, 1: debounced button level, 0 = pressed.
- press_pulse, output, 1: one-cycle high strobe on each accepted press (1→0 transition of btn_db_n).
- pause_n, output, 1: run/pause level to the adder; 1 = run, 0 = paused. Toggles on every press_pulse.

Behaviour:
- Reset (rst_n=0, async): synchroniser flops = 1, btn_db_n = 1, press_pulse = 0, pause_n = 1 (counting runs), counter = 0, FSM = REL.
- Synchroniser: btn_n passes through SYNC_STAGES flops; the last stage is s_n. Only s_n feeds the logic.
- FSM states:
  - REL (stable released, btn_db_n=1): if s_n=0, go to DB_PRESS with counter = 1; else counter = 0.
  - DB_PRESS: if s_n=1, go to REL with counter = 0 (bounce rejected).
    - Else, if counter = CNT_MAX-1: go to PRS, set btn_db_n = 0, assert press_pulse for this one cycle, and pause_n <= ~pause_n.
    - Else counter++.
  - PRS (stable pressed, btn_db_n=0): if s_n=1, go to DB_REL with counter = 1; else counter = 0.
  - DB_REL: if s_n=0, go to PRS with counter = 0.
    - Else, if counter = CNT_MAX-1: go to REL and set btn_db_n = 1. No pulse, no toggle.
    - Else counter++.
- Latency: after btn_n settles, btn_db_n and pause_n update on clock edge SYNC_STAGES + CNT_MAX (counted from the first edge that samples the settled level). press_pulse is high for exactly that one cycle.
- Release never toggles pause_n. A press held indefinitely yields exactly one pulse.
- Glitches shorter than CNT_MAX cycles after synchronisation produce no output change. The counter restarts from 0 on every bounce.
- The counter saturates by design: it never exceeds CNT_MAX-1 and never wraps.
- Reset mid-debounce: all state cleared immediately and pause_n returns to 1. A still-held button after reset is debounced afresh and counts as a new press.
- All outputs are registered; there are no combinational paths from btn_n.

Decomposition:
- Shared package (lab_pkg): the FSM state enum (REL, DB_PRESS, PRS, DB_REL) and the board constant CLK_HZ = 100_000_000, from which CNT_MAX is derived in the top level.
- One sub-module, sync_ff: parameterised SYNC_STAGES-deep synchroniser with async active-low reset value 1. It is reusable for the rst-independent inputs of other labs.

Test Plan (run with SYNC_STAGES=2, CNT_MAX=8):
- Reset check: hold rst_n=0, btn_n=1 → btn_db_n=1, pause_n=1, press_pulse=0. Assert rst_n=0 mid-DB_PRESS → outputs return to these values in the same cycle.
- Clean press: btn_n 1→0 and held → press_pulse high for exactly 1 cycle at edge 10 after the change, btn_db_n=0 and pause_n=0 from that edge. Further holding produces no pulses.
- Bounce rejection: btn_n toggles 0/1 every 3 cycles for 40 cycles, then returns to 1 → press_pulse never asserts, pause_n stays 1.
- Bounce then settle: 5 bounces of 2–5 cycles each, then hold 0 → exactly one pulse, 10 cycles after the final 1→0 transition. The release bounce that follows yields no pulse.
- Toggle sequence: 3 clean press/release cycles, each phase held 20 cycles → pause_n goes 1→0→1→0, with exactly 3 press_pulse strobes.
- Boundary: low pulse of exactly CNT_MAX-1 = 7 synchronised cycles → rejected. 8 cycles → accepted with one pulse.
